// File: rtl/ibex_msg_pkg.sv
// rtl/ibex_msg_pkg.sv - shared types and helpers for the MPRF message injection path
package ibex_msg_pkg;

   localparam int unsigned MsgMaxWords = 4;
   localparam int unsigned MsgLenW     = 2;
   localparam int unsigned MsgAddrW    = 5;
   localparam int unsigned MsgDataW    = 32;
   localparam int unsigned MsgNumWords = 2 ** MsgAddrW;

   typedef struct packed {
      logic [MsgAddrW-1:0]                  addr;
      logic [MsgLenW-1:0]                   len;
      logic [MsgMaxWords-1:0][MsgDataW-1:0] data;
   } msg_desc_t;

   typedef enum logic {
      MSG_IDLE,
      MSG_WRITE
   } msg_wr_state_e;

   // Registers touched by a message; the address wraps modulo the MPRF size.
   function automatic logic [MsgNumWords-1:0] target_mask(input logic [MsgAddrW-1:0] addr,
                                                          input logic [MsgLenW-1:0]  len);
      logic [MsgNumWords-1:0] mask;
      logic [MsgAddrW-1:0]    a;
      mask = '0;
      for (int k = 0; k < int'(MsgMaxWords); k++) begin
         a = addr + MsgAddrW'(k);
         if (MsgLenW'(k) <= len) begin
            mask[a] = 1'b1;
         end
      end
      return mask;
   endfunction

endpackage

// File: rtl/ibex_msg_desc_fifo.sv
// rtl/ibex_msg_desc_fifo.sv - synchronous-reset descriptor queue for the MPRF write scheduler
module ibex_msg_desc_fifo
   import ibex_msg_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      push_i,
   input  msg_desc_t wdata_i,
   input  logic      pop_i,
   output msg_desc_t rdata_o,
   output logic      full_o,
   output logic      empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = $clog2(Depth + 1);

   msg_desc_t       mem_q [Depth];
   logic [PtrW-1:0] wptr_q;
   logic [PtrW-1:0] rptr_q;
   logic [CntW-1:0] count_q;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CntW'(Depth));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;
   assign rdata_o = mem_q[rptr_q];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wptr_q <= ptr_inc(wptr_q);
         end
         if (do_pop) begin
            rptr_q <= ptr_inc(rptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Payload storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/ibex_msg_rf_wr_ctrl.sv
// rtl/ibex_msg_rf_wr_ctrl.sv - MPRF injection write scheduler with pending-word scoreboard
module ibex_msg_rf_wr_ctrl
   import ibex_msg_pkg::*;
#(
   parameter int unsigned AddrWidth = MsgAddrW,
   parameter int unsigned DataWidth = MsgDataW,
   parameter int unsigned FifoDepth = 2,
   localparam int unsigned NumWords = 2 ** AddrWidth
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   msg_valid_i,
   output logic                   msg_ready_o,
   input  logic [AddrWidth-1:0]   msg_addr_i,
   input  logic [1:0]             msg_len_i,
   input  logic [4*DataWidth-1:0] msg_data_i,
   input  logic                   core_we_i,
   input  logic                   core_mprf_sel_i,
   output logic                   rf_we_o,
   output logic [AddrWidth-1:0]   rf_waddr_o,
   output logic [DataWidth-1:0]   rf_wdata_o,
   output logic [NumWords-1:0]    pending_o,
   output logic                   busy_o,
   output logic                   done_o
);

   msg_wr_state_e        state_q, state_d;
   msg_desc_t            work_q, work_d;
   logic [MsgLenW-1:0]   cnt_q, cnt_d;
   logic [NumWords-1:0]  pending_q, pending_d;
   logic [NumWords-1:0]  in_mask;
   logic [NumWords-1:0]  clr_mask;
   logic [AddrWidth-1:0] wr_addr;
   msg_desc_t            in_desc;
   msg_desc_t            fifo_head;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic                 accept;
   logic                 stall;

   assign in_desc = {msg_addr_i, msg_len_i, msg_data_i};
   assign in_mask = target_mask(msg_addr_i, msg_len_i);

   // Refusing overlap with pending words keeps set and clear of the scoreboard disjoint.
   assign msg_ready_o = ~rst_i & ~fifo_full & ~|(in_mask & pending_q);
   assign accept      = msg_valid_i & msg_ready_o;

   ibex_msg_desc_fifo #(
      .Depth(FifoDepth)
   ) u_desc_fifo (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .push_i (accept),
      .wdata_i(in_desc),
      .pop_i  (fifo_pop),
      .rdata_o(fifo_head),
      .full_o (fifo_full),
      .empty_o(fifo_empty)
   );

   assign stall   = core_we_i & core_mprf_sel_i;
   assign wr_addr = work_q.addr + AddrWidth'(cnt_q);

   always_comb begin
      state_d    = state_q;
      work_d     = work_q;
      cnt_d      = cnt_q;
      fifo_pop   = 1'b0;
      clr_mask   = '0;
      rf_we_o    = 1'b0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      done_o     = 1'b0;
      case (state_q)
         MSG_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               work_d   = fifo_head;
               cnt_d    = '0;
               state_d  = MSG_WRITE;
            end
         end
         MSG_WRITE: begin
            // Address and data stay on the port while the core owns it.
            rf_waddr_o = wr_addr;
            rf_wdata_o = work_q.data[cnt_q];
            if (!stall) begin
               rf_we_o           = 1'b1;
               clr_mask[wr_addr] = 1'b1;
               if (cnt_q == work_q.len) begin
                  done_o = 1'b1;
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     work_d   = fifo_head;
                     cnt_d    = '0;
                  end else begin
                     state_d = MSG_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = MSG_IDLE;
      endcase
   end

   assign pending_d = (pending_q & ~clr_mask) | (accept ? in_mask : '0);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= MSG_IDLE;
         work_q    <= '0;
         cnt_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
      end
   end

   assign pending_o = pending_q;
   assign busy_o    = ~fifo_empty | (state_q != MSG_IDLE);

endmodule

// File: tb/tb_ibex_msg_rf_wr_ctrl.sv
// tb/tb_ibex_msg_rf_wr_ctrl.sv - directed self-checking bench for the MPRF write scheduler
module tb_ibex_msg_rf_wr_ctrl;

   logic         clk_i;
   logic         rst_i;
   logic         msg_valid_i;
   logic         msg_ready_o;
   logic [4:0]   msg_addr_i;
   logic [1:0]   msg_len_i;
   logic [127:0] msg_data_i;
   logic         core_we_i;
   logic         core_mprf_sel_i;
   logic         rf_we_o;
   logic [4:0]   rf_waddr_o;
   logic [31:0]  rf_wdata_o;
   logic [31:0]  pending_o;
   logic         busy_o;
   logic         done_o;

   int n_checks = 0;
   int n_fail   = 0;

   ibex_msg_rf_wr_ctrl #(
      .AddrWidth(5),
      .DataWidth(32),
      .FifoDepth(2)
   ) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .msg_valid_i    (msg_valid_i),
      .msg_ready_o    (msg_ready_o),
      .msg_addr_i     (msg_addr_i),
      .msg_len_i      (msg_len_i),
      .msg_data_i     (msg_data_i),
      .core_we_i      (core_we_i),
      .core_mprf_sel_i(core_mprf_sel_i),
      .rf_we_o        (rf_we_o),
      .rf_waddr_o     (rf_waddr_o),
      .rf_wdata_o     (rf_wdata_o),
      .pending_o      (pending_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset;
      rst_i = 1'b1;
      msg_valid_i = 1'b0;
      msg_addr_i = '0;
      msg_len_i = '0;
      msg_data_i = '0;
      core_we_i = 1'b0;
      core_mprf_sel_i = 1'b0;
      tick();
      tick();
      @(negedge clk_i);
      n_checks++;
      if ({rf_we_o, rf_waddr_o, rf_wdata_o, done_o, busy_o, pending_o} !== 71'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got we=%0b a=%0d d=%h done=%0b busy=%0b pend=%h, want all 0",
                  rf_we_o, rf_waddr_o, rf_wdata_o, done_o, busy_o, pending_o);
      end
      tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if ({msg_ready_o, busy_o, pending_o} !== {1'b1, 1'b0, 32'h0}) begin
         n_fail++;
         $display("FAIL reset_ready: got ready=%0b busy=%0b pend=%h, want ready=1 busy=0 pend=0",
                  msg_ready_o, busy_o, pending_o);
      end
      tick();
   endtask

   // Shared shape for single/collision/wrap: accept at cycle 0, then check cycles 1..6.
   task automatic run_one(input string name, input logic [4:0] addr, input logic [1:0] len,
                          input logic [127:0] data, input int stall_cyc, input int gprf_cyc,
                          input int e_we[7], input int e_addr[7], input int e_data[7],
                          input int e_done[7], input int e_pend[7], input int last);
      msg_valid_i = 1'b1;
      msg_addr_i  = addr;
      msg_len_i   = len;
      msg_data_i  = data;
      @(negedge clk_i);
      n_checks++;
      if (msg_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_ready: got %0b want 1", name, msg_ready_o);
      end
      tick();
      msg_valid_i = 1'b0;
      for (int c = 1; c <= last; c++) begin
         core_we_i       = (c == stall_cyc) || (c == gprf_cyc);
         core_mprf_sel_i = (c == stall_cyc);
         @(negedge clk_i);
         n_checks++;
         if ({rf_we_o, rf_waddr_o, rf_wdata_o, done_o, pending_o} !==
             {1'(e_we[c]), 5'(e_addr[c]), 32'(e_data[c]), 1'(e_done[c]), 32'(e_pend[c])}) begin
            n_fail++;
            $display("FAIL %s c%0d: got we=%0b a=%0d d=%h done=%0b pend=%h want we=%0d a=%0d d=%h done=%0d pend=%h",
                     name, c, rf_we_o, rf_waddr_o, rf_wdata_o, done_o, pending_o,
                     e_we[c], e_addr[c], e_data[c], e_done[c], e_pend[c]);
         end
         tick();
      end
      core_we_i       = 1'b0;
      core_mprf_sel_i = 1'b0;
   endtask

   task automatic test_single;
      int e_we[7]   = '{0, 0, 1, 1, 1, 0, 0};
      int e_addr[7] = '{0, 0, 5, 6, 7, 0, 0};
      int e_data[7] = '{0, 0, 'hA0, 'hB1, 'hC2, 0, 0};
      int e_done[7] = '{0, 0, 0, 0, 1, 0, 0};
      int e_pend[7] = '{0, 'hE0, 'hE0, 'hC0, 'h80, 0, 0};
      run_one("single", 5'd5, 2'd2, {32'hDEADBEEF, 32'hC2, 32'hB1, 32'hA0}, 0, 0,
              e_we, e_addr, e_data, e_done, e_pend, 5);
   endtask

   task automatic test_collision;
      int e_we[7]   = '{0, 0, 1, 0, 1, 1, 0};
      int e_addr[7] = '{0, 0, 5, 6, 6, 7, 0};
      int e_data[7] = '{0, 0, 'hA0, 'hB1, 'hB1, 'hC2, 0};
      int e_done[7] = '{0, 0, 0, 0, 0, 1, 0};
      int e_pend[7] = '{0, 'hE0, 'hE0, 'hC0, 'hC0, 'h80, 0};
      run_one("collision", 5'd5, 2'd2, {32'hDEADBEEF, 32'hC2, 32'hB1, 32'hA0}, 3, 2,
              e_we, e_addr, e_data, e_done, e_pend, 6);
   endtask

   task automatic test_wrap;
      int e_we[7]   = '{0, 0, 1, 1, 1, 1, 0};
      int e_addr[7] = '{0, 0, 30, 31, 0, 1, 0};
      int e_data[7] = '{0, 0, 'h11, 'h22, 'h33, 'h44, 0};
      int e_done[7] = '{0, 0, 0, 0, 0, 1, 0};
      int e_pend[7] = '{0, 'hC0000003, 'hC0000003, 'h80000003, 'h3, 'h2, 0};
      run_one("wrap", 5'd30, 2'd3, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0,
              e_we, e_addr, e_data, e_done, e_pend, 6);
   endtask

   task automatic test_back_to_back;
      int v[11]      = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      int a[11]      = '{0, 8, 12, 16, 16, 16, 16, 0, 0, 0, 0};
      int l[11]      = '{3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      int e_rdy[11]  = '{1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0};
      int e_we[11]   = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      int e_addr[11] = '{0, 0, 0, 1, 2, 3, 8, 9, 12, 16, 0};
      int e_done[11] = '{0, 0, 0, 0, 0, 1, 0, 1, 1, 1, 0};
      int e_busy[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
      msg_data_i = {32'h3, 32'h2, 32'h1, 32'h0};
      for (int c = 0; c < 11; c++) begin
         msg_valid_i = v[c][0];
         msg_addr_i  = 5'(a[c]);
         msg_len_i   = 2'(l[c]);
         @(negedge clk_i);
         if (v[c] != 0) begin
            n_checks++;
            if (msg_ready_o !== 1'(e_rdy[c])) begin
               n_fail++;
               $display("FAIL b2b_ready c%0d: got %0b want %0d", c, msg_ready_o, e_rdy[c]);
            end
         end
         n_checks++;
         if ({rf_we_o, rf_waddr_o, done_o, busy_o} !==
             {1'(e_we[c]), 5'(e_addr[c]), 1'(e_done[c]), 1'(e_busy[c])}) begin
            n_fail++;
            $display("FAIL b2b c%0d: got we=%0b a=%0d done=%0b busy=%0b want we=%0d a=%0d done=%0d busy=%0d",
                     c, rf_we_o, rf_waddr_o, done_o, busy_o, e_we[c], e_addr[c], e_done[c], e_busy[c]);
         end
         tick();
      end
      msg_valid_i = 1'b0;
   endtask

   task automatic test_overlap;
      int v[9]      = '{1, 0, 1, 1, 1, 1, 1, 0, 0};
      int e_rdy[9]  = '{1, 0, 0, 0, 0, 0, 1, 0, 0};
      int e_we[9]   = '{0, 0, 1, 1, 1, 1, 0, 0, 1};
      int e_addr[9] = '{0, 0, 4, 5, 6, 7, 0, 0, 7};
      int e_data[9] = '{0, 0, 'h1D, 'h2D, 'h3D, 'h4D, 0, 0, 'h1D};
      int e_done[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};
      msg_data_i = {32'h4D, 32'h3D, 32'h2D, 32'h1D};
      for (int c = 0; c < 9; c++) begin
         msg_valid_i = v[c][0];
         msg_addr_i  = (c == 0) ? 5'd4 : 5'd7;
         msg_len_i   = (c == 0) ? 2'd3 : 2'd0;
         @(negedge clk_i);
         if (c <= 6) begin
            n_checks++;
            if (msg_ready_o !== 1'(e_rdy[c])) begin
               n_fail++;
               $display("FAIL overlap_ready c%0d: got %0b want %0d", c, msg_ready_o, e_rdy[c]);
            end
         end
         n_checks++;
         if ({rf_we_o, rf_waddr_o, rf_wdata_o, done_o} !==
             {1'(e_we[c]), 5'(e_addr[c]), 32'(e_data[c]), 1'(e_done[c])}) begin
            n_fail++;
            $display("FAIL overlap c%0d: got we=%0b a=%0d d=%h done=%0b want we=%0d a=%0d d=%h done=%0d",
                     c, rf_we_o, rf_waddr_o, rf_wdata_o, done_o, e_we[c], e_addr[c], e_data[c], e_done[c]);
         end
         tick();
      end
      msg_valid_i = 1'b0;
   endtask

   task automatic test_reset_mid;
      int v[10]      = '{1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
      int e_we[10]   = '{0, 0, 1, 1, 0, 0, 0, 0, 1, 0};
      int e_addr[10] = '{0, 0, 20, 21, 0, 0, 0, 0, 2, 0};
      int e_data[10] = '{0, 0, 'h400, 'h401, 0, 0, 0, 0, 'h500, 0};
      int e_done[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
      int e_busy[10] = '{0, 1, 1, 1, 0, 0, 0, 1, 1, 0};
      int e_pend[10] = '{0, 'hF00000, 'hF00000, 'hE00000, 0, 0, 0, 'h4, 'h4, 0};
      for (int c = 0; c < 10; c++) begin
         msg_valid_i = v[c][0];
         rst_i       = (c == 4);
         msg_addr_i  = (c < 6) ? 5'd20 : 5'd2;
         msg_len_i   = (c < 6) ? 2'd3 : 2'd0;
         msg_data_i  = (c < 6) ? {32'h403, 32'h402, 32'h401, 32'h400} : {96'h0, 32'h500};
         @(negedge clk_i);
         if (v[c] != 0) begin
            n_checks++;
            if (msg_ready_o !== 1'b1) begin
               n_fail++;
               $display("FAIL rstmid_ready c%0d: got %0b want 1", c, msg_ready_o);
            end
         end
         if (c != 4) begin
            n_checks++;
            if ({rf_we_o, rf_waddr_o, rf_wdata_o, done_o, busy_o, pending_o} !==
                {1'(e_we[c]), 5'(e_addr[c]), 32'(e_data[c]), 1'(e_done[c]), 1'(e_busy[c]), 32'(e_pend[c])}) begin
               n_fail++;
               $display("FAIL rstmid c%0d: got we=%0b a=%0d d=%h done=%0b busy=%0b pend=%h want we=%0d a=%0d d=%h done=%0d busy=%0d pend=%h",
                        c, rf_we_o, rf_waddr_o, rf_wdata_o, done_o, busy_o, pending_o,
                        e_we[c], e_addr[c], e_data[c], e_done[c], e_busy[c], e_pend[c]);
            end
         end
         tick();
      end
      msg_valid_i = 1'b0;
      rst_i       = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single();
      test_collision();
      test_wrap();
      test_back_to_back();
      test_overlap();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
